// File: rtl/p_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : p (package)
//  Description : Shared record type, arbiter state encoding and output-beat
//                record for the p_t round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package p;

    // Payload record consumed downstream through its a/b fields
    typedef struct packed {
        byte a;
        byte b;
    } p_t;

    // Arbiter state: IDLE arbitrates, BURST forwards beats of the granted source
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Contents of the single output register
    typedef struct packed {
        p_t   data;
        logic last;
    } p_beat_t;

endpackage : p
`default_nettype wire

// File: rtl/p_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin priority selector. Returns the
//                first asserted request at or after ptr, wrapping past the
//                highest index back to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // One spare bit so ptr+offset never overflows before the wrap compare
    localparam int                  c_CAND_W   = IDX_W + 1;
    localparam logic [c_CAND_W-1:0] c_LAST_IDX = c_CAND_W'(N_REQ - 1);
    localparam logic [c_CAND_W-1:0] c_N_REQ    = c_CAND_W'(N_REQ);

    logic [c_CAND_W-1:0] w_cand;

    // Walk the candidates in priority order starting at ptr; first hit wins
    always_comb begin
        idx    = '0;
        found  = 1'b0;
        w_cand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, ptr} + c_CAND_W'(k);
            // Explicit compare keeps the wrap correct for non-power-of-two N_REQ
            if (w_cand > c_LAST_IDX) begin
                w_cand = w_cand - c_N_REQ;
            end
            if (!found && req[w_cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/p_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : p_rr_arbiter
//  Description : Burst-granular round-robin arbiter sharing one registered
//                p_t output channel between N_REQ valid/ready requesters.
//                Each forwarded beat is tagged with its source index; bursts
//                longer than MAX_BURST beats are cut with a forced last.
//  Revision    : 1.0 - initial release
// ============================================================================
module p_rr_arbiter
    import p::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4,
    localparam int SRC_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_valid,
    input  logic [N_REQ-1:0] req_last,
    input  p_t               req_data [N_REQ],
    output logic [N_REQ-1:0] req_ready,
    output logic             out_valid,
    output p_t               out_data,
    output logic [SRC_W-1:0] out_src,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [7:0]       c_LAST_BEAT = 8'(MAX_BURST - 1);
    localparam logic [SRC_W-1:0] c_LAST_IDX  = SRC_W'(N_REQ - 1);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [SRC_W-1:0] r_gnt;
    logic [SRC_W-1:0] r_ptr;
    logic [7:0]       r_beat_cnt;
    p_beat_t          r_out;
    logic             r_out_valid;
    logic [SRC_W-1:0] r_out_src;

    logic [SRC_W-1:0] w_pick_idx;
    logic             w_pick_found;
    logic             w_out_free;
    logic             w_xfer;
    logic             w_beat_last;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (r_ptr),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    // Output register is free when empty or being drained this cycle
    assign w_out_free  = !r_out_valid || out_ready;
    assign w_xfer      = (r_state == BURST) && req_valid[r_gnt] && w_out_free;
    assign w_beat_last = req_last[r_gnt] || (r_beat_cnt == c_LAST_BEAT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and ready decode; only the granted requester can see ready
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                req_ready[r_gnt] = w_out_free;
                if (w_xfer && w_beat_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant capture, beat counting and round-robin pointer advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt      <= '0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_pick_found) begin
                r_gnt      <= w_pick_idx;
                r_beat_cnt <= '0;
            end
        end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (w_beat_last) begin
                r_ptr <= (r_gnt == c_LAST_IDX) ? '0 : r_gnt + SRC_W'(1);
            end
        end
    end

    // Output register: load on transfer, empty when drained with nothing new
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
        end else if (w_xfer) begin
            r_out.data  <= req_data[r_gnt];
            r_out.last  <= w_beat_last;
            r_out_src   <= r_gnt;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out.data;
    assign out_last  = r_out.last;
    assign out_src   = r_out_src;
    assign busy      = (r_state == BURST);

endmodule : p_rr_arbiter
`default_nettype wire

// File: doc/p_rr_arbiter.md
# p_rr_arbiter

Round-robin arbiter that shares one registered `p_t` output channel (packed `{byte a; byte b;}`) between `N_REQ` requesters. Each requester streams bursts of `p_t` beats with valid/ready handshakes. The arbiter grants one requester per burst, forwards its beats through a single output register, and tags each beat with the source index. It sits between the producers of `p_t` records and the single downstream consumer that uses `ps.a`/`ps.b`.

## Interface
- `N_REQ`, 4: number of requesters (2..16)
- `MAX_BURST`, 4: maximum beats per grant before forced release (1..255)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req_valid` in N_REQ: per-requester beat valid
- `req_last` in N_REQ: per-requester end-of-burst marker, sampled with the beat
- `req_data` in N_REQ x p_t: per-requester payload, unpacked array of `p::p_t`
- `req_ready` out N_REQ: per-requester beat accept, at most one bit high
- `out_valid` out 1: output beat valid
- `out_data` out p_t: output payload
- `out_src` out $clog2(N_REQ): index of the requester that produced `out_data`
- `out_last` out 1: last beat of the burst, either requested or forced
- `out_ready` in 1: downstream accept
- `busy` out 1: high while in state BURST

## Operation
- The FSM uses `arb_state_e` with two states, IDLE and BURST.
- **IDLE:**
  - `req_ready` is all zero.
  - If any `req_valid` is high, `rr_pick` selects the first valid index at or after `ptr`, with wrap-around.
  - `gnt` is registered, `beat_cnt` is cleared, and the FSM moves to BURST.
  - If no requester is valid, the FSM stays in IDLE.
- **BURST:**
  - `req_ready[gnt] = !out_valid || out_ready`, so the output register is either empty or draining this cycle.
  - A beat transfers when `req_valid[gnt] && req_ready[gnt]`. On transfer:
    - `out_data <= req_data[gnt]`
    - `out_src <= gnt`
    - `out_valid <= 1`
    - `out_last <= req_last[gnt] || (beat_cnt == MAX_BURST-1)`
    - `beat_cnt` increments.
  - If the transferred beat has `out_last` set, then `ptr <= gnt+1` (mod N_REQ), the FSM returns to IDLE, and the grant is released.
  - If `req_valid[gnt]` drops mid-burst, the grant stays locked and the FSM remains in BURST waiting. Requesters must not abandon a burst.
- **Output register:** on `out_valid && out_ready` with no new transfer, `out_valid <= 0`. Data holds stable while `out_valid && !out_ready`.
- Requesters not granted never see `req_ready` high. Their `req_valid`/`req_data` must stay stable until accepted.
- Arithmetic:
  - `beat_cnt` is 8 bits and compares against `MAX_BURST-1`.
  - `ptr` wrap uses an explicit compare to `N_REQ-1`, not a power-of-two mask.
- Reset values: `out_valid`, `out_last`, `busy`, `req_ready` = 0; `out_data` = '0; `out_src` = 0; `ptr` = 0; `gnt` = 0; `beat_cnt` = 0; state IDLE.
- Reset mid-burst discards the in-flight beat and the rest of the burst. After reset, arbitration restarts at index 0.

## Timing
- First-beat latency: `req_valid` high in cycle 0 (IDLE) → `req_ready` high in cycle 1 → `out_valid` high in cycle 2.
- Throughput in BURST is one beat per cycle while `out_ready` is held high.
- There is one arbitration bubble cycle (IDLE) between consecutive bursts.
- Backpressure: with `out_valid` high and `out_ready` low, `req_ready` is 0 in the same cycle (combinational from `out_ready`).
- All other outputs are registered.

## Structure
- Package `p` holds:
  - existing `p_t`
  - `typedef enum logic {IDLE, BURST} arb_state_e`
  - `typedef struct packed {p_t data; logic last;} p_beat_t`, used for the output register
- Sub-module `rr_pick` is a combinational round-robin priority selector: inputs `req[N_REQ]` and `ptr`; outputs `idx` and `found`. Verify it standalone.
- `p_rr_arbiter` contains the FSM, counters and output register. It imports `p::*`.

## Test plan
- **Single burst:** req 2 sends beats {a=AA,b=55}, {a=01,b=02}, with `req_last` on the 2nd beat and `out_ready=1`.
  - Out beats appear in cycles 2 and 3 with `out_src=2`.
  - `out_last` is set on the 2nd beat.
  - `ptr` becomes 3.
- **Round-robin fairness:** all 4 requesters hold `req_valid` with single-beat bursts (`req_last=1`) and `out_ready=1`.
  - `out_src` sequence is 0,1,2,3,0.
  - One idle cycle separates beats.
- **Forced release:** `MAX_BURST=4`, req 1 streams 6 beats and never asserts `req_last`.
  - Beat 4 has `out_last=1`.
  - The grant moves to the next valid requester.
  - The remaining 2 beats form a later burst.
- **Backpressure:** `out_ready=0` for 3 cycles mid-burst.
  - `out_data` holds stable.
  - `req_ready[gnt]` stays 0.
  - No beat is lost or duplicated; the received beat count equals the sent count.
- **Wrap-around:** `ptr=3` and only req 1 is valid.
  - Grant goes to 1.
  - `ptr` becomes 2 after its last beat.
- **Reset mid-burst:** assert `rst_n=0` asynchronously during beat 2 of req 3.
  - `out_valid` and `req_ready` drop immediately.
  - After release, the first grant follows index order starting at 0.
